// File: rtl/viterbi_ber_monitor_pkg.sv
// Shared state type and default tuning constants for the Viterbi BER monitor.
package viterbi_pkg;

  typedef enum logic [1:0] {SEARCH, CONFIRM, TRACK} ber_state_t;

  localparam int SYNC_LEN_DEF  = 32;
  localparam int WIN_DEF       = 256;
  localparam int LOSS_THR_DEF  = 16;
  localparam int LOSS_WINS_DEF = 2;

endpackage

// File: rtl/viterbi_ber_monitor_ref_delay.sv
// Reference-bit history with a latency-indexed tap; the tap is combinational and
// shows the pre-shift history, so a same-cycle shift never affects the current compare.
module ber_ref_delay #(
  parameter int MAX_LAT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_i,
  input  logic                       bit_i,
  input  logic [$clog2(MAX_LAT)-1:0] sel_i,
  output logic                       bit_o
);

  logic [MAX_LAT-1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (shift_i) begin
      hist <= {hist[MAX_LAT-2:0], bit_i};
    end
  end

  assign bit_o = hist[sel_i];

endmodule

// File: rtl/viterbi_ber_monitor.sv
// BER monitor: searches the decoder latency, confirms it over one window, then tracks
// per-window and total bit errors; all outputs registered, one cycle after the deciding bit.
module viterbi_ber_monitor
  import viterbi_pkg::*;
#(
  parameter int MAX_LAT   = 64,
  parameter int SYNC_LEN  = SYNC_LEN_DEF,
  parameter int SYNC_THR  = 2,
  parameter int WIN       = WIN_DEF,
  parameter int LOSS_THR  = LOSS_THR_DEF,
  parameter int LOSS_WINS = LOSS_WINS_DEF,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ref_valid_i,
  input  logic                       ref_bit_i,
  input  logic                       dec_valid_i,
  input  logic                       dec_bit_i,
  input  logic                       clr_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] lat_o,
  output logic [$clog2(WIN+1)-1:0]   win_err_o,
  output logic                       win_done_o,
  output logic [CNT_W-1:0]           err_cnt_o,
  output logic [CNT_W-1:0]           bit_cnt_o,
  output logic                       sync_fail_o
);

  localparam int LW = $clog2(MAX_LAT);
  localparam int CW = $clog2(WIN+1);
  localparam int BW = $clog2(LOSS_WINS+1);

  ber_state_t    state, state_n;
  logic [LW-1:0] lat_n, lat_adv;
  logic          lat_wrap;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [CW-1:0] errs, errs_n, errs_inc;
  logic [CW-1:0] win_err_n;
  logic [BW-1:0] bad, bad_n;
  logic          win_done_n, sync_fail_n;
  logic          ref_bit, err;

  ber_ref_delay #(.MAX_LAT(MAX_LAT)) u_ref_delay (
    .clk     (clk),
    .rst     (rst),
    .shift_i (ref_valid_i),
    .bit_i   (ref_bit_i),
    .sel_i   (lat_o),
    .bit_o   (ref_bit)
  );

  assign err      = dec_bit_i ^ ref_bit;
  assign cnt_inc  = cnt + CW'(1);
  assign errs_inc = errs + CW'(err);
  // A failing candidate moves to the next latency; running off the end restarts the sweep.
  assign lat_wrap = (lat_o == LW'(MAX_LAT-1));
  assign lat_adv  = lat_wrap ? '0 : lat_o + LW'(1);

  always_comb begin
    state_n     = state;
    lat_n       = lat_o;
    cnt_n       = cnt;
    errs_n      = errs;
    bad_n       = bad;
    win_done_n  = 1'b0;
    win_err_n   = win_err_o;
    sync_fail_n = 1'b0;
    if (dec_valid_i) begin
      cnt_n  = cnt_inc;
      errs_n = errs_inc;
      unique case (state)
        SEARCH: begin
          if (cnt_inc == CW'(SYNC_LEN)) begin
            cnt_n  = '0;
            errs_n = '0;
            if (errs_inc <= CW'(SYNC_THR)) begin
              state_n = CONFIRM;
            end else begin
              lat_n       = lat_adv;
              sync_fail_n = lat_wrap;
            end
          end
        end
        CONFIRM: begin
          if (cnt_inc == CW'(WIN)) begin
            cnt_n      = '0;
            errs_n     = '0;
            win_done_n = 1'b1;
            win_err_n  = errs_inc;
            if (errs_inc <= CW'(LOSS_THR)) begin
              state_n = TRACK;
            end else begin
              state_n     = SEARCH;
              lat_n       = lat_adv;
              sync_fail_n = lat_wrap;
            end
          end
        end
        TRACK: begin
          if (cnt_inc == CW'(WIN)) begin
            cnt_n      = '0;
            errs_n     = '0;
            win_done_n = 1'b1;
            win_err_n  = errs_inc;
            if (errs_inc > CW'(LOSS_THR)) begin
              // Loss keeps lat so the old latency is the first one re-tested.
              if (bad + BW'(1) == BW'(LOSS_WINS)) begin
                state_n = SEARCH;
                bad_n   = '0;
              end else begin
                bad_n = bad + BW'(1);
              end
            end else begin
              bad_n = '0;
            end
          end
        end
        default: begin
          state_n = SEARCH;
          cnt_n   = '0;
          errs_n  = '0;
          bad_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      lat_o       <= '0;
      cnt         <= '0;
      errs        <= '0;
      bad         <= '0;
      locked_o    <= 1'b0;
      win_done_o  <= 1'b0;
      win_err_o   <= '0;
      sync_fail_o <= 1'b0;
    end else begin
      state       <= state_n;
      lat_o       <= lat_n;
      cnt         <= cnt_n;
      errs        <= errs_n;
      bad         <= bad_n;
      locked_o    <= (state_n == TRACK);
      win_done_o  <= win_done_n;
      win_err_o   <= win_err_n;
      sync_fail_o <= sync_fail_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_o <= '0;
      bit_cnt_o <= '0;
    end else if (clr_i) begin
      err_cnt_o <= '0;
      bit_cnt_o <= '0;
    end else if (dec_valid_i && state == TRACK) begin
      if (bit_cnt_o != '1) bit_cnt_o <= bit_cnt_o + CNT_W'(1);
      if (err && err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Bench: PRBS-7 loopback with programmable delay; window results checked through a scoreboard.
module tb_viterbi_ber_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ref_valid = 1'b0, ref_bit = 1'b0, dec_valid = 1'b0, dec_bit = 1'b0, clr = 1'b0;
  logic        locked, win_done, sync_fail;
  logic [5:0]  lat;
  logic [8:0]  win_err;
  logic [31:0] err_cnt, bit_cnt;
  logic        s_locked, s_win_done, s_sync_fail;
  logic [5:0]  s_lat;
  logic [8:0]  s_win_err;
  logic [3:0]  s_err_cnt, s_bit_cnt;

  viterbi_ber_monitor dut (
    .clk(clk), .rst(rst), .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
    .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clr_i(clr),
    .locked_o(locked), .lat_o(lat), .win_err_o(win_err), .win_done_o(win_done),
    .err_cnt_o(err_cnt), .bit_cnt_o(bit_cnt), .sync_fail_o(sync_fail)
  );

  viterbi_ber_monitor #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
    .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clr_i(clr),
    .locked_o(s_locked), .lat_o(s_lat), .win_err_o(s_win_err), .win_done_o(s_win_done),
    .err_cnt_o(s_err_cnt), .bit_cnt_o(s_bit_cnt), .sync_fail_o(s_sync_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int scen;
    int bit_no;
    int exp_lat;
    bit exp_locked;
  } cp_t;
  cp_t cp[$];

  int     n_tests = 0, n_fail = 0;
  logic [6:0] lfsr = 7'h7F;
  bit     rbits[$];
  int     delay = 7, exp_lat = 0, nbits = 0;
  bit     invert = 0, gaps = 0, sb_on = 0, in_trk = 0, any_lock = 0;
  int     sb_pos = 0, sb_err = 0;
  int     sb_q[$];
  int     sf_q[$];
  longint exp_err = 0, exp_bits = 0, base_err;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit ref_at(input int k);
    if (k < 0 || k >= rbits.size()) return 1'b0;
    return rbits[k];
  endfunction

  task automatic monitor();
    int x;
    if (locked) any_lock = 1;
    if (sync_fail) sf_q.push_back(nbits - 1);
    if (win_done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL win_done_unexpected: got pulse with err %0d expected none", win_err);
      end else begin
        x = sb_q.pop_front();
        check("win_err", win_err, x);
      end
    end
  endtask

  task automatic drive_bit(input bit flip, input bit clr_b);
    int n;
    bit rb, db, e;
    n    = rbits.size();
    rb   = lfsr[6] ^ lfsr[5];
    lfsr = {lfsr[5:0], rb};
    db   = ref_at(n - 1 - delay) ^ flip ^ invert;
    e    = db ^ ref_at(n - 1 - exp_lat);
    rbits.push_back(rb);
    ref_valid = 1'b1; ref_bit = rb; dec_valid = 1'b1; dec_bit = db; clr = clr_b;
    @(posedge clk); #1;
    ref_valid = 1'b0; dec_valid = 1'b0; clr = 1'b0;
    nbits++;
    if (sb_on) begin
      sb_err += int'(e);
      sb_pos++;
      if (sb_pos == 256) begin
        sb_q.push_back(sb_err);
        sb_pos = 0;
        sb_err = 0;
      end
    end
    if (clr_b) begin
      exp_err = 0;
      exp_bits = 0;
    end else if (in_trk) begin
      exp_bits++;
      exp_err += longint'(e);
    end
    monitor();
  endtask

  task automatic idle_step();
    ref_valid = 1'b0; dec_valid = 1'b0;
    ref_bit = 1'($urandom); dec_bit = 1'($urandom);
    @(posedge clk); #1;
    monitor();
  endtask

  task automatic run_windows(input int nwin, input int nflip);
    bit flip;
    for (int w = 0; w < nwin; w++) begin
      for (int p = 0; p < 256; p++) begin
        if (gaps && (p % 37) == 36) idle_step();
        flip = 1'b0;
        if (nflip > 0) flip = ((p % (256 / nflip)) == 3);
        drive_bit(flip, 1'b0);
      end
    end
  endtask

  task automatic acquire(input int scen, input int lat_true, input int start_lat);
    int nsearch;
    nsearch = (lat_true - start_lat + 1) * 32;
    for (int i = 0; i < nsearch + 256; i++) begin
      if (i == nsearch) begin
        sb_on = 1; sb_pos = 0; sb_err = 0; exp_lat = lat_true;
      end
      drive_bit(1'b0, 1'b0);
      foreach (cp[j]) begin
        if (cp[j].scen == scen && cp[j].bit_no == i) begin
          check($sformatf("s%0d_lat@%0d", scen, i), lat, cp[j].exp_lat);
          check($sformatf("s%0d_locked@%0d", scen, i), locked, cp[j].exp_locked);
        end
      end
    end
    in_trk = 1;
  endtask

  task automatic do_reset();
    ref_valid = 1'b0; dec_valid = 1'b0; clr = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_locked", locked, 0);
    check("rst_lat", lat, 0);
    check("rst_win_err", win_err, 0);
    check("rst_win_done", win_done, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_sync_fail", sync_fail, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    lfsr = 7'h7F; rbits.delete(); sb_q.delete(); sf_q.delete();
    sb_on = 0; sb_pos = 0; sb_err = 0; in_trk = 0; any_lock = 0; invert = 0;
    exp_err = 0; exp_bits = 0; nbits = 0; delay = 7; exp_lat = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: sweep from 0 to true latency 7, then one CONFIRM window.
    cp.push_back('{1, 0, 0, 0});
    for (int k = 1; k <= 7; k++) cp.push_back('{1, 32 * k - 1, k, 0});
    cp.push_back('{1, 255, 7, 0});
    cp.push_back('{1, 300, 7, 0});
    cp.push_back('{1, 510, 7, 0});
    cp.push_back('{1, 511, 7, 1});
    // Scenario 2: re-search after loss starts at the old latency 7, true latency 9.
    cp.push_back('{2, 31, 8, 0});
    cp.push_back('{2, 63, 9, 0});
    cp.push_back('{2, 95, 9, 0});
    cp.push_back('{2, 350, 9, 0});
    cp.push_back('{2, 351, 9, 1});

    @(posedge clk); #1;
    do_reset();

    delay = 7;
    acquire(1, 7, 0);
    gaps = 1;
    run_windows(2, 0);
    gaps = 0;
    check("clean_drained", sb_q.size(), 0);
    check("clean_err_cnt", err_cnt, 0);
    check("clean_bit_cnt", bit_cnt, exp_bits);

    run_windows(1, 5);
    check("five_err_cnt", err_cnt, 5);
    check("five_locked", locked, 1);
    check("five_bit_cnt", bit_cnt, exp_bits);

    run_windows(17, 1);
    check("sat_err_cnt", s_err_cnt, 15);
    check("sat_bit_cnt", s_bit_cnt, 15);
    check("wide_err_cnt", err_cnt, exp_err);
    drive_bit(1'b1, 1'b1);
    check("clr_err_cnt", err_cnt, 0);
    check("clr_bit_cnt", bit_cnt, 0);
    check("clr_sat_err", s_err_cnt, 0);
    check("clr_sat_bit", s_bit_cnt, 0);
    drive_bit(1'b0, 1'b0);
    check("post_clr_bit", bit_cnt, 1);
    check("post_clr_err", err_cnt, 0);
    while (sb_pos != 0) drive_bit(1'b0, 1'b0);

    base_err = exp_err;
    delay = 9;
    run_windows(1, 0);
    check("jump_locked_w1", locked, 1);
    run_windows(1, 0);
    check("jump_locked_w2", locked, 0);
    in_trk = 0; sb_on = 0;
    check("jump_err_cnt", err_cnt, exp_err);
    check("jump_err_band", ((exp_err - base_err) >= 192 && (exp_err - base_err) <= 320), 1);
    check("jump_drained", sb_q.size(), 0);
    acquire(2, 9, 7);
    check("relock_err_hold", err_cnt, exp_err);
    for (int i = 0; i < 100; i++) drive_bit(1'b0, 1'b0);
    check("relock_bit_cnt", bit_cnt, exp_bits);
    check("no_sync_fail", sf_q.size(), 0);

    do_reset();
    acquire(1, 7, 0);
    run_windows(1, 0);
    check("rst_relock_drained", sb_q.size(), 0);

    do_reset();
    invert = 1;
    for (int i = 0; i < 4096; i++) drive_bit(1'b0, 1'b0);
    check("nocorr_fail_count", sf_q.size(), 2);
    if (sf_q.size() == 2) begin
      check("nocorr_fail_1", sf_q[0], 2047);
      check("nocorr_fail_2", sf_q[1], 4095);
    end
    check("nocorr_never_locked", any_lock, 0);
    check("nocorr_lat_wrapped", lat, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
